axi_slave_mem_responder: RTL

- AXI slave endpoint that sits downstream of the master driver on the shared AXI interface. It consumes AW/W/AR traffic and produces B and R responses, so the protocol checker on that interface sees a live, compliant responder.
- Backed by a byte-strobed word memory with INCR bursts.
- Write and read paths run as independent FSMs.

---
 rtl/axi_slv_pkg.sv | 16 +
 rtl/axi_slave_mem_responder_if.sv | 69 ++++++
 rtl/axi_slv_mem.sv | 30 +++
 rtl/axi_slave_mem_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/axi_slv_pkg.sv
// Shared types and helpers for the AXI slave memory responder.
// Response codes, FSM state types and the transfer-size check.
package axi_slv_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // A transfer size is usable only when it moves exactly one full data word.
    function automatic logic size_ok(input logic [2:0] size, input int data_width);
        return (8 << size) == data_width;
    endfunction

endpackage

// File: rtl/axi_slave_mem_responder_if.sv
// AXI bus bundle between a master driver and the memory responder.
// Carries AW/W/B/AR/R channels; clock and reset travel separately.
interface axi_slave_mem_responder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADD_WIDTH  = 8,
    parameter int ID_WIDTH   = 8
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic                  awvalid;
    logic                  awready;
    logic [ADD_WIDTH-1:0]  awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [ID_WIDTH-1:0]   awid;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BYTES-1:0]      wstrb;
    logic                  wlast;
    logic [ID_WIDTH-1:0]   wid;

    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;

    logic                  arvalid;
    logic                  arready;
    logic [ADD_WIDTH-1:0]  araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [ID_WIDTH-1:0]   arid;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic [ID_WIDTH-1:0]   rid;
    logic [1:0]            rresp;

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast, wid,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, araddr, arlen, arsize, arid,
        output arready,
        output rvalid, rdata, rlast, rid, rresp,
        input  rready
    );

    modport master (
        output awvalid, awaddr, awlen, awsize, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast, wid,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, araddr, arlen, arsize, arid,
        input  arready,
        input  rvalid, rdata, rlast, rid, rresp,
        output rready
    );

endinterface

// File: rtl/axi_slv_mem.sv
// Word-organised storage with one byte-strobed synchronous write port
// and one asynchronous read port. Contents are never reset.
module axi_slv_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 128,
    localparam int BYTES     = DATA_WIDTH / 8,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BYTES-1:0]      wstrb,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_slave_mem_responder.sv
// AXI slave endpoint backed by a byte-strobed word memory with INCR bursts.
// Write (AW/W/B) and read (AR/R) paths run as independent FSMs.
module axi_slave_mem_responder
    import axi_slv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADD_WIDTH  = 8,
    parameter int ID_WIDTH   = 8
) (
    input logic                      aclk,
    input logic                      areset,
    axi_slave_mem_responder_if.slave bus
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = ADD_WIDTH - LSB;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] IDX_ONE = 1;

    wr_state_t             wr_state;
    logic                  awready_q, wready_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic [ID_WIDTH-1:0]   wr_id;
    logic [IDX_W-1:0]      wr_idx;
    logic [7:0]            wr_len, wr_cnt;
    logic                  wr_err, wr_size_ok;
    logic                  w_beat, w_beat_err, mem_we;

    rd_state_t             rd_state;
    logic                  arready_q, rvalid_q, rlast_q;
    logic [1:0]            rresp_q;
    logic [ID_WIDTH-1:0]   rd_id;
    logic [DATA_WIDTH-1:0] rdata_q, mem_rdata, rd_word;
    logic [IDX_W-1:0]      rd_idx, rd_raddr;
    logic [7:0]            rd_len, rd_cnt;
    logic                  rd_size_ok;

    // Address bits below the word boundary carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.awaddr, bus.araddr};

    assign w_beat     = (wr_state == W_DATA) && bus.wvalid && wready_q;
    assign w_beat_err = (bus.wid != wr_id) || (bus.wlast != (wr_cnt == wr_len));
    assign mem_we     = w_beat && wr_size_ok;

    assign rd_raddr = (rd_state == R_IDLE) ? bus.araddr[ADD_WIDTH-1:LSB] : rd_idx + IDX_ONE;

    // Forward a same-cycle write so the next loaded beat sees post-write data.
    always_comb begin
        rd_word = mem_rdata;
        if (mem_we && (wr_idx == rd_raddr)) begin
            for (int i = 0; i < BYTES; i++) begin
                if (bus.wstrb[i]) rd_word[i*8 +: 8] = bus.wdata[i*8 +: 8];
            end
        end
    end

    axi_slv_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (aclk),
        .we    (mem_we),
        .waddr (wr_idx),
        .wdata (bus.wdata),
        .wstrb (bus.wstrb),
        .raddr (rd_raddr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            wr_state   <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_id      <= '0;
            wr_idx     <= '0;
            wr_len     <= '0;
            wr_cnt     <= '0;
            wr_err     <= 1'b0;
            wr_size_ok <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (bus.awvalid && awready_q) begin
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        wr_id      <= bus.awid;
                        wr_idx     <= bus.awaddr[ADD_WIDTH-1:LSB];
                        wr_len     <= bus.awlen;
                        wr_cnt     <= '0;
                        wr_err     <= 1'b0;
                        wr_size_ok <= size_ok(bus.awsize, DATA_WIDTH);
                        wr_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        wr_idx <= wr_idx + IDX_ONE;
                        wr_cnt <= wr_cnt + 8'd1;
                        if (w_beat_err || !wr_size_ok) wr_err <= 1'b1;
                        // Beat count alone terminates the burst; a bad wlast only flags an error.
                        if (wr_cnt == wr_len) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (wr_err || w_beat_err || !wr_size_ok) ? RESP_SLVERR : RESP_OKAY;
                            wr_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wr_state  <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            rd_state   <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rd_id      <= '0;
            rdata_q    <= '0;
            rd_idx     <= '0;
            rd_len     <= '0;
            rd_cnt     <= '0;
            rd_size_ok <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (bus.arvalid && arready_q) begin
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rd_id      <= bus.arid;
                        rd_idx     <= bus.araddr[ADD_WIDTH-1:LSB];
                        rd_len     <= bus.arlen;
                        rd_cnt     <= '0;
                        rlast_q    <= (bus.arlen == 8'd0);
                        rd_size_ok <= size_ok(bus.arsize, DATA_WIDTH);
                        rresp_q    <= size_ok(bus.arsize, DATA_WIDTH) ? RESP_OKAY : RESP_SLVERR;
                        rdata_q    <= size_ok(bus.arsize, DATA_WIDTH) ? rd_word : '0;
                        rd_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid_q && bus.rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rd_state  <= R_IDLE;
                        end else begin
                            rd_idx  <= rd_idx + IDX_ONE;
                            rd_cnt  <= rd_cnt + 8'd1;
                            rlast_q <= ((rd_cnt + 8'd1) == rd_len);
                            rdata_q <= rd_size_ok ? rd_word : '0;
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = wr_id;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rlast   = rlast_q;
    assign bus.rid     = rd_id;
    assign bus.rresp   = rresp_q;

endmodule
